// File: rtl/fetch_unit_if.sv
// Fetch-side bundle between the decoder, the fetch unit and the memory bus.
// slave: fetch unit view; master: decoder/memory view.
interface fetch_unit_if;
    logic        rd;
    logic [1:0]  t_cycle;
    logic        m1t1;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [7:0]  data_bus_out;
    logic        data_valid;
    logic        stall;
    logic [15:0] pc;
    logic        bus_err;
    logic        fetch_overrun;

    modport slave (
        input  rd, t_cycle, m1t1, pc_load, pc_load_val, mem_ack, mem_data,
        output mem_addr, mem_rd_req, data_bus_out, data_valid, stall, pc,
        bus_err, fetch_overrun
    );

    modport master (
        output rd, t_cycle, m1t1, pc_load, pc_load_val, mem_ack, mem_data,
        input  mem_addr, mem_rd_req, data_bus_out, data_valid, stall, pc,
        bus_err, fetch_overrun
    );
endinterface

// File: rtl/fetch_unit.sv
// Opcode fetch responder: owns the PC, issues memory reads on decoder rd edges,
// handles wait states, T4 stall and MAX_WAIT abort.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          MAX_WAIT   = 16,
    parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait;
    logic          r_rd_q;
    logic [15:0]   r_pc;
    logic [15:0]   r_mem_addr;
    logic          r_mem_rd_req;
    logic [7:0]    r_data;
    logic          r_data_valid;
    logic          r_stall;
    logic          r_bus_err;
    logic          r_overrun;
    logic          w_req_ev;
    logic          w_ack;

    assign w_req_ev = bus.rd && !r_rd_q;
    assign w_ack    = r_mem_rd_req && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_rd_q       <= 1'b0;
            r_pc         <= RESET_PC;
            r_mem_addr   <= '0;
            r_mem_rd_req <= 1'b0;
            r_data       <= NOP_OPCODE;
            r_data_valid <= 1'b0;
            r_stall      <= 1'b0;
            r_bus_err    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rd_q <= bus.rd;
            case (r_state)
                S_IDLE: begin
                    if (w_req_ev) begin
                        r_mem_addr   <= r_pc;
                        r_mem_rd_req <= 1'b1;
                        r_wait       <= '0;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_req_ev) r_overrun <= 1'b1;
                    if (w_ack) begin
                        r_data       <= bus.mem_data;
                        r_data_valid <= 1'b1;
                        r_mem_rd_req <= 1'b0;
                        r_stall      <= 1'b0;
                        r_pc         <= r_pc + 16'd1;
                        r_state      <= S_DONE;
                    end else if (r_wait == WAIT_LAST) begin
                        // Abort keeps the PC so the next rd re-fetches the same address
                        r_mem_rd_req <= 1'b0;
                        r_data       <= NOP_OPCODE;
                        r_data_valid <= 1'b1;
                        r_bus_err    <= 1'b1;
                        r_stall      <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                        if (bus.t_cycle == 2'b11) r_stall <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_req_ev) r_overrun <= 1'b1;
                    if (bus.m1t1) begin
                        r_data_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Jump target wins over the post-fetch increment
            if (bus.pc_load) r_pc <= bus.pc_load_val;
        end
    end

    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_rd_req    = r_mem_rd_req;
    assign bus.data_bus_out  = r_data;
    assign bus.data_valid    = r_data_valid;
    assign bus.stall         = r_stall;
    assign bus.pc            = r_pc;
    assign bus.bus_err       = r_bus_err;
    assign bus.fetch_overrun = r_overrun;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; all checks go through check().
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .MAX_WAIT  (16),
        .NOP_OPCODE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rd pulse: the edge sampling rd=1 issues the request
    task automatic rd_pulse();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic ack_with(input logic [7:0] d);
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        tick();
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
    endtask

    task automatic m1t1_release();
        bus.m1t1 = 1'b1;
        tick();
        bus.m1t1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.rd = 1'b0; bus.t_cycle = 2'b00; bus.m1t1 = 1'b0;
        bus.pc_load = 1'b0; bus.pc_load_val = 16'h0000;
        bus.mem_ack = 1'b0; bus.mem_data = 8'h00;

        // Reset state
        tick(); tick();
        check("rst_pc",      bus.pc, 16'h0000);
        check("rst_addr",    bus.mem_addr, 16'h0000);
        check("rst_req",     16'(bus.mem_rd_req), 16'd0);
        check("rst_data",    16'(bus.data_bus_out), 16'h0000);
        check("rst_valid",   16'(bus.data_valid), 16'd0);
        check("rst_stall",   16'(bus.stall), 16'd0);
        check("rst_buserr",  16'(bus.bus_err), 16'd0);
        check("rst_overrun", 16'(bus.fetch_overrun), 16'd0);
        rst = 1'b1;
        tick();

        // Basic fetch
        rd_pulse();
        check("basic_req",  16'(bus.mem_rd_req), 16'd1);
        check("basic_addr", bus.mem_addr, 16'h0000);
        check("basic_novalid", 16'(bus.data_valid), 16'd0);
        ack_with(8'h3E);
        check("basic_data",  16'(bus.data_bus_out), 16'h003E);
        check("basic_valid", 16'(bus.data_valid), 16'd1);
        check("basic_pc",    bus.pc, 16'h0001);
        check("basic_reqlo", 16'(bus.mem_rd_req), 16'd0);
        tick();
        check("basic_hold_valid", 16'(bus.data_valid), 16'd1);
        m1t1_release();
        check("basic_m1_valid", 16'(bus.data_valid), 16'd0);
        check("basic_m1_data",  16'(bus.data_bus_out), 16'h003E);

        // Wait states with T4 stall
        rd_pulse();
        check("ws_addr", bus.mem_addr, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            bus.t_cycle = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : 2'b11;
            tick();
            check("ws_addr_stable", bus.mem_addr, 16'h0001);
            check("ws_req",   16'(bus.mem_rd_req), 16'd1);
            check("ws_stall", 16'(bus.stall), (i >= 2) ? 16'd1 : 16'd0);
        end
        ack_with(8'hA7);
        check("ws_stall_clr", 16'(bus.stall), 16'd0);
        check("ws_data",  16'(bus.data_bus_out), 16'h00A7);
        check("ws_valid", 16'(bus.data_valid), 16'd1);
        check("ws_pc",    bus.pc, 16'h0002);
        bus.t_cycle = 2'b00;
        m1t1_release();

        // Timeout after MAX_WAIT cycles
        rd_pulse();
        check("to_addr", bus.mem_addr, 16'h0002);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_req_held", 16'(bus.mem_rd_req), 16'd1);
        end
        tick();
        check("to_req",    16'(bus.mem_rd_req), 16'd0);
        check("to_data",   16'(bus.data_bus_out), 16'h0000);
        check("to_valid",  16'(bus.data_valid), 16'd1);
        check("to_buserr", 16'(bus.bus_err), 16'd1);
        check("to_pc",     bus.pc, 16'h0002);
        check("to_stall",  16'(bus.stall), 16'd0);
        m1t1_release();
        rd_pulse();
        check("to_refetch_addr", bus.mem_addr, 16'h0002);
        check("to_refetch_req",  16'(bus.mem_rd_req), 16'd1);
        ack_with(8'h55);
        check("to_refetch_data", 16'(bus.data_bus_out), 16'h0055);
        check("to_refetch_pc",   bus.pc, 16'h0003);
        check("to_buserr_sticky", 16'(bus.bus_err), 16'd1);
        m1t1_release();

        // pc_load coinciding with ack
        rd_pulse();
        check("pl_addr", bus.mem_addr, 16'h0003);
        bus.pc_load = 1'b1; bus.pc_load_val = 16'h0150;
        ack_with(8'h99);
        bus.pc_load = 1'b0;
        check("pl_pc",    bus.pc, 16'h0150);
        check("pl_data",  16'(bus.data_bus_out), 16'h0099);
        check("pl_valid", 16'(bus.data_valid), 16'd1);
        m1t1_release();

        // Wrap at 0xFFFF
        bus.pc_load = 1'b1; bus.pc_load_val = 16'hFFFF;
        tick();
        bus.pc_load = 1'b0;
        check("wrap_load", bus.pc, 16'hFFFF);
        rd_pulse();
        check("wrap_addr", bus.mem_addr, 16'hFFFF);
        ack_with(8'h12);
        check("wrap_pc",   bus.pc, 16'h0000);
        check("wrap_data", 16'(bus.data_bus_out), 16'h0012);
        m1t1_release();

        // Overrun: rd edge while in DONE
        rd_pulse();
        ack_with(8'h34);
        check("ov_pre", 16'(bus.fetch_overrun), 16'd0);
        rd_pulse();
        check("ov_flag",  16'(bus.fetch_overrun), 16'd1);
        check("ov_noreq", 16'(bus.mem_rd_req), 16'd0);
        check("ov_valid", 16'(bus.data_valid), 16'd1);
        check("ov_pc",    bus.pc, 16'h0001);
        m1t1_release();
        tick();
        check("ov_sticky", 16'(bus.fetch_overrun), 16'd1);

        // Reset mid-fetch
        rd_pulse();
        check("rmf_req", 16'(bus.mem_rd_req), 16'd1);
        check("rmf_addr", bus.mem_addr, 16'h0001);
        rst = 1'b0;
        tick();
        check("rmf_req_lo", 16'(bus.mem_rd_req), 16'd0);
        check("rmf_pc",     bus.pc, 16'h0000);
        check("rmf_valid",  16'(bus.data_valid), 16'd0);
        check("rmf_ovr",    16'(bus.fetch_overrun), 16'd0);
        check("rmf_buserr", 16'(bus.bus_err), 16'd0);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
